// File: rtl/seg_anim_pkg.sv
// seg_anim_pkg: glyph constants, mode encoding and position-to-frame mapping for the circle chaser.
package seg_anim_pkg;

    localparam int MAX_DIGITS = 16;

    localparam logic [7:0] UPPER_CIRCLE = 8'b0110_0011;
    localparam logic [7:0] LOWER_CIRCLE = 8'b0101_1100;
    localparam logic [7:0] SEG_BLANK    = 8'hFF;

    typedef enum logic {
        MODE_WRAP   = 1'b0,
        MODE_BOUNCE = 1'b1
    } mode_e;

    // Active-high frame: upper half left to right, lower half right to left.
    function automatic logic [8*MAX_DIGITS-1:0] pos_to_frame(input int p, input int ndig);
        logic [8*MAX_DIGITS-1:0] upper;
        logic [8*MAX_DIGITS-1:0] lower;
        upper = {{(8*(MAX_DIGITS-1)){1'b0}}, UPPER_CIRCLE};
        lower = {{(8*(MAX_DIGITS-1)){1'b0}}, LOWER_CIRCLE};
        return (p < ndig) ? upper << (8 * p) : lower << (8 * (2 * ndig - 1 - p));
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: divides clk_i down to one animation tick every (TICK_DIV >> speed_i) enabled cycles.
module step_prescaler #(
    parameter  int TICK_DIV = 12_500_000,
    localparam int CW       = $clog2(TICK_DIV)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [2:0] speed_i,
    output logic       tick_o
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] limit;
    int            lim_raw;

    always_comb begin
        lim_raw = (TICK_DIV >> speed_i) - 1;
        limit   = (lim_raw < 1) ? CW'(1) : CW'(lim_raw);
    end

    // >= so a speed increase that leaves cnt beyond the new limit ticks at once
    assign tick_o = en_i && (cnt >= limit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (en_i) begin
            cnt <= tick_o ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_circle_chaser.sv
// seg_circle_chaser: walks a circle glyph around a 7-seg bank in wrap or bounce mode.
// Define SEG_CHASER_TRAIL_EN to also light the previous position as a trail.
module seg_circle_chaser
    import seg_anim_pkg::*;
#(
    parameter  int NUM_DIGITS = 6,
    parameter  int TICK_DIV   = 12_500_000,
    localparam int POS_W      = $clog2(2 * NUM_DIGITS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    dir_i,
    input  logic                    mode_i,
    input  logic [2:0]              speed_i,
    output logic [8*NUM_DIGITS-1:0] seg7_o,
    output logic [POS_W-1:0]        pos_o,
    output logic                    step_o
);

    localparam logic [POS_W-1:0] P_LAST = POS_W'(2 * NUM_DIGITS - 1);

    logic                    tick;
    logic [POS_W-1:0]        p;
    logic [POS_W-1:0]        p_nxt;
    logic                    cur_dir;
    logic                    dir_nxt;
    logic                    at_end;
    logic [8*MAX_DIGITS-1:0] frame;

    step_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_presc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .speed_i(speed_i),
        .tick_o (tick)
    );

    // Bouncing at a loop end flips direction and steps back in the same tick.
    always_comb begin
        at_end  = cur_dir ? (p == '0) : (p == P_LAST);
        dir_nxt = (mode_e'(mode_i) == MODE_BOUNCE) ? (cur_dir ^ at_end) : dir_i;
        p_nxt   = dir_nxt ? ((p == '0) ? P_LAST : p - 1'b1)
                          : ((p == P_LAST) ? '0 : p + 1'b1);
    end

`ifdef SEG_CHASER_TRAIL_EN
    logic [POS_W-1:0] p_prev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_prev <= '0;
        end else if (tick) begin
            p_prev <= p;
        end
    end

    assign frame = pos_to_frame(int'(p), NUM_DIGITS) | pos_to_frame(int'(p_prev), NUM_DIGITS);
`else
    assign frame = pos_to_frame(int'(p), NUM_DIGITS);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p       <= '0;
            cur_dir <= 1'b0;
            step_o  <= 1'b0;
            seg7_o  <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            step_o <= tick;
            seg7_o <= ~frame[8*NUM_DIGITS-1:0];
            if (tick) begin
                p       <= p_nxt;
                cur_dir <= dir_nxt;
            end
        end
    end

    assign pos_o = p;

endmodule

// File: tb/tb_seg_circle_chaser.sv
// tb_seg_circle_chaser: directed checks of reset, wrap, bounce, pause, speed change and trail.
module tb_seg_circle_chaser;

    localparam int ND = 6;
    localparam int TD = 8;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          en_i = 1'b0;
    logic          dir_i = 1'b0;
    logic          mode_i = 1'b0;
    logic [2:0]    speed_i = 3'd0;
    logic [8*ND-1:0] seg7_o;
    logic [3:0]    pos_o;
    logic          step_o;

    int total = 0;
    int bad = 0;

    seg_circle_chaser #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .dir_i  (dir_i),
        .mode_i (mode_i),
        .speed_i(speed_i),
        .seg7_o (seg7_o),
        .pos_o  (pos_o),
        .step_o (step_o)
    );

    always #5 clk = ~clk;

    // Returns edges until step_o is seen, or -1 if none within max.
    task automatic wait_step(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            #1;
            if (step_o) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++; if (seg7_o !== 48'hFFFF_FFFF_FFFF) begin bad++; $display("FAIL reset_seg7 got=%h exp=%h", seg7_o, 48'hFFFF_FFFF_FFFF); end
        total++; if (pos_o !== 4'd0) begin bad++; $display("FAIL reset_pos got=%0d exp=0", pos_o); end
        total++; if (step_o !== 1'b0) begin bad++; $display("FAIL reset_step got=%b exp=0", step_o); end
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        total++; if (seg7_o !== 48'hFFFF_FFFF_FF9C) begin bad++; $display("FAIL first_frame got=%h exp=%h", seg7_o, 48'hFFFF_FFFF_FF9C); end
        total++; if (pos_o !== 4'd0) begin bad++; $display("FAIL first_pos got=%0d exp=0", pos_o); end
    endtask

    task automatic test_wrap_fwd;
        int n;
        en_i = 1'b1; dir_i = 1'b0; mode_i = 1'b0; speed_i = 3'd0;
        for (int i = 1; i <= 12; i++) begin
            wait_step(20, n);
            total++; if (n !== 8) begin bad++; $display("FAIL fwd_period step=%0d got=%0d exp=8", i, n); end
            total++; if (pos_o !== 4'(i % 12)) begin bad++; $display("FAIL fwd_pos step=%0d got=%0d exp=%0d", i, pos_o, i % 12); end
            if (i == 7) begin
                total++; if (seg7_o !== 48'hA3FF_FFFF_FFFF) begin bad++; $display("FAIL frame_p6 got=%h exp=%h", seg7_o, 48'hA3FF_FFFF_FFFF); end
            end
            if (i == 12) begin
                total++; if (seg7_o !== 48'hFFFF_FFFF_FFA3) begin bad++; $display("FAIL frame_p11 got=%h exp=%h", seg7_o, 48'hFFFF_FFFF_FFA3); end
            end
        end
    endtask

    task automatic test_wrap_rev;
        int n;
        dir_i = 1'b1;
        wait_step(20, n);
        total++; if (n !== 8) begin bad++; $display("FAIL rev_period got=%0d exp=8", n); end
        total++; if (pos_o !== 4'd11) begin bad++; $display("FAIL rev_wrap got=%0d exp=11", pos_o); end
        speed_i = 3'd2;
        for (int i = 0; i < 2; i++) begin
            wait_step(20, n);
            total++; if (n !== 2) begin bad++; $display("FAIL speed2_period got=%0d exp=2", n); end
            total++; if (pos_o !== 4'(10 - i)) begin bad++; $display("FAIL speed2_pos got=%0d exp=%0d", pos_o, 10 - i); end
        end
        speed_i = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++; if (step_o !== 1'b0) begin bad++; $display("FAIL precount_step cyc=%0d got=%b exp=0", i, step_o); end
        end
        speed_i = 3'd2;
        wait_step(20, n);
        total++; if (n !== 1) begin bad++; $display("FAIL speed_raise got=%0d exp=1", n); end
        total++; if (pos_o !== 4'd8) begin bad++; $display("FAIL speed_raise_pos got=%0d exp=8", pos_o); end
    endtask

    task automatic test_bounce;
        int n;
        int seq[15] = '{10, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
        dir_i = 1'b0;
        wait_step(20, n);
        total++; if (pos_o !== 4'd9) begin bad++; $display("FAIL bounce_start got=%0d exp=9", pos_o); end
        mode_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            dir_i = ~dir_i;
            wait_step(20, n);
            total++; if (n !== 2) begin bad++; $display("FAIL bounce_period idx=%0d got=%0d exp=2", i, n); end
            total++; if (pos_o !== 4'(seq[i])) begin bad++; $display("FAIL bounce_pos idx=%0d got=%0d exp=%0d", i, pos_o, seq[i]); end
        end
    endtask

    task automatic test_pause;
        int n;
        mode_i = 1'b0; dir_i = 1'b0; speed_i = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        en_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            total++; if (pos_o !== 4'd2) begin bad++; $display("FAIL pause_pos cyc=%0d got=%0d exp=2", i, pos_o); end
            total++; if (seg7_o !== 48'hFFFF_FF9C_FFFF) begin bad++; $display("FAIL pause_seg cyc=%0d got=%h exp=%h", i, seg7_o, 48'hFFFF_FF9C_FFFF); end
            total++; if (step_o !== 1'b0) begin bad++; $display("FAIL pause_step cyc=%0d got=%b exp=0", i, step_o); end
        end
        en_i = 1'b1;
        wait_step(20, n);
        total++; if (n !== 5) begin bad++; $display("FAIL resume_remaining got=%0d exp=5", n); end
        total++; if (pos_o !== 4'd3) begin bad++; $display("FAIL resume_pos got=%0d exp=3", pos_o); end
    endtask

    task automatic test_reset_and_trail;
        int n;
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        total++; if (seg7_o !== 48'hFFFF_FFFF_FFFF) begin bad++; $display("FAIL async_seg got=%h exp=%h", seg7_o, 48'hFFFF_FFFF_FFFF); end
        total++; if (pos_o !== 4'd0) begin bad++; $display("FAIL async_pos got=%0d exp=0", pos_o); end
        @(negedge clk);
        speed_i = 3'd2;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        total++; if (seg7_o !== 48'hFFFF_FFFF_FF9C) begin bad++; $display("FAIL trail_first got=%h exp=%h", seg7_o, 48'hFFFF_FFFF_FF9C); end
        for (int i = 0; i < 6; i++) wait_step(20, n);
        total++; if (pos_o !== 4'd6) begin bad++; $display("FAIL trail_pos got=%0d exp=6", pos_o); end
        @(posedge clk);
        #1;
`ifdef SEG_CHASER_TRAIL_EN
        total++; if (seg7_o !== 48'h80FF_FFFF_FFFF) begin bad++; $display("FAIL trail_frame got=%h exp=%h", seg7_o, 48'h80FF_FFFF_FFFF); end
`else
        total++; if (seg7_o !== 48'hA3FF_FFFF_FFFF) begin bad++; $display("FAIL single_frame got=%h exp=%h", seg7_o, 48'hA3FF_FFFF_FFFF); end
`endif
    endtask

    initial begin
        test_reset();
        test_wrap_fwd();
        test_wrap_rev();
        test_bounce();
        test_pause();
        test_reset_and_trail();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
